// File: rtl/binary_encoder_8to3_pkg.sv
// ---------------------------------------------------------------------------
// binary_encoder_8to3_pkg
// Shared widths and the one-hot decode helper for the 8-to-3 encoder slice.
//   IN_W          : one-hot select width (8)
//   OUT_W         : encoded index width (3)
//   encode_onehot : bit position k of a one-hot select -> k; anything that is
//                   not exactly one-hot (zero or multi-hot) -> 3'b000
// ---------------------------------------------------------------------------
package binary_encoder_8to3_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 3;

    // Straight table lookup with no priority: only the eight exact one-hot
    // patterns map to a nonzero index.  Every other value falls to 000.
    function automatic logic [OUT_W-1:0] encode_onehot(input logic [IN_W-1:0] sel);
        logic [OUT_W-1:0] idx;
        case (sel)
            8'h01:   idx = 3'd0;
            8'h02:   idx = 3'd1;
            8'h04:   idx = 3'd2;
            8'h08:   idx = 3'd3;
            8'h10:   idx = 3'd4;
            8'h20:   idx = 3'd5;
            8'h40:   idx = 3'd6;
            8'h80:   idx = 3'd7;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/binary_encoder_8to3.sv
// ---------------------------------------------------------------------------
// binary_encoder_8to3
// Combinational core: turns an 8-bit one-hot select back into a 3-bit index.
// Ports:
//   in  [7:0] : one-hot select, bit k set encodes index k
//   out [2:0] : encoded index; 000 for non-one-hot input, xxx if in has X/Z
// ---------------------------------------------------------------------------
module binary_encoder_8to3
    import binary_encoder_8to3_pkg::*;
(
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    // The unknown check has to come before the table lookup.  A case default
    // would quietly turn an unknown select into 000, which hides a broken
    // upstream decoder in simulation.  Synthesis sees only the lookup.
    always_comb begin
        out = '0;
        if ($isunknown(in)) begin
            out = 'x;
        end else begin
            out = encode_onehot(in);
        end
    end

endmodule

// File: rtl/binary_encoder_8to3_reg.sv
// ---------------------------------------------------------------------------
// binary_encoder_8to3_reg
// Registered 8-to-3 one-hot encoder with classification flags.
// Ports:
//   clk       : rising-edge clock for the registered outputs
//   rst_n     : asynchronous active-low reset, clears all registered outputs
//   in  [7:0] : one-hot select
//   en        : capture enable for the registered outputs
//   out [2:0] : combinational encoded index (zero latency)
//   out_q     : registered copy of out
//   onehot_q  : registered flag, in had exactly one bit set
//   zero_q    : registered flag, in was all zeros
//   multi_q   : registered flag, in had two or more bits set
// ---------------------------------------------------------------------------
module binary_encoder_8to3_reg
    import binary_encoder_8to3_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             onehot_q,
    output logic             zero_q,
    output logic             multi_q
);

    logic onehot;
    logic zero;
    logic multi;

    // The combinational core drives the zero-latency output directly.
    binary_encoder_8to3 u_core (
        .in  (in),
        .out (out)
    );

    // Classify the select by its population count.  For a fully known input
    // exactly one flag is set; an unknown input makes all three unknown so
    // the flags never claim a clean classification of garbage.
    always_comb begin
        onehot = 1'b0;
        zero   = 1'b0;
        multi  = 1'b0;
        if ($isunknown(in)) begin
            onehot = 1'bx;
            zero   = 1'bx;
            multi  = 1'bx;
        end else begin
            onehot = ($countones(in) == 1);
            zero   = (in == '0);
            multi  = ($countones(in) >= 2);
        end
    end

    // Capture registers for downstream stages.  Reset is asynchronous, so it
    // clears the outputs immediately and also beats a coincident capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            onehot_q <= 1'b0;
            zero_q   <= 1'b0;
            multi_q  <= 1'b0;
        end else if (en) begin
            out_q    <= out;
            onehot_q <= onehot;
            zero_q   <= zero;
            multi_q  <= multi;
        end
    end

endmodule

// File: tb/tb_binary_encoder_8to3_reg.sv
// ---------------------------------------------------------------------------
// tb_binary_encoder_8to3_reg
// Directed, table-driven bench for binary_encoder_8to3_reg.
// ---------------------------------------------------------------------------
module tb_binary_encoder_8to3_reg;

    typedef struct {
        logic [7:0] sel;
        logic [2:0] exp_out;
        logic       exp_onehot;
        logic       exp_zero;
        logic       exp_multi;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       en;
    logic [2:0] out;
    logic [2:0] out_q;
    logic       onehot_q;
    logic       zero_q;
    logic       multi_q;

    int compared;
    int mismatched;

    vec_t vecs [11];

    binary_encoder_8to3_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .en       (en),
        .out      (out),
        .out_q    (out_q),
        .onehot_q (onehot_q),
        .zero_q   (zero_q),
        .multi_q  (multi_q)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: case-inequality so unknowns are compared exactly.
    task automatic checkOutput(input string name, input logic [2:0] actual,
                               input logic [2:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Drive a new select/enable on the falling edge, away from capture.
    task automatic applyStimulus(input logic [7:0] sel, input logic enable);
        @(negedge clk);
        in = sel;
        en = enable;
    endtask

    task automatic checkRegs(input string tag, input logic [2:0] e_out,
                             input logic e_one, input logic e_zero, input logic e_multi);
        checkOutput({tag, " out_q"},    out_q,            e_out);
        checkOutput({tag, " onehot_q"}, {2'b00, onehot_q}, {2'b00, e_one});
        checkOutput({tag, " zero_q"},   {2'b00, zero_q},   {2'b00, e_zero});
        checkOutput({tag, " multi_q"},  {2'b00, multi_q},  {2'b00, e_multi});
    endtask

    initial begin
        logic xprobe;
        logic four_state;

        compared   = 0;
        mismatched = 0;

        vecs[0]  = '{8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'h02, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h04, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h08, 3'd3, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{8'h10, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'h20, 3'd5, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'h40, 3'd6, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'h80, 3'd7, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'h03, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{8'h24, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{8'h00, 3'd0, 1'b0, 1'b1, 1'b0};

        // Reset state, asserted before any clock edge.
        rst_n = 1'b0;
        in    = 8'h00;
        en    = 1'b0;
        #2;
        checkRegs("reset", 3'd0, 1'b0, 1'b0, 1'b0);

        // Reset held low across a capture edge with en=1: reset must win.
        in = 8'h80;
        en = 1'b1;
        @(posedge clk);
        #1;
        checkRegs("reset_vs_edge", 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset comb out", out, 3'd7);

        @(negedge clk);
        rst_n = 1'b1;

        // Table sweep: combinational result now, registered result after edge.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].sel, 1'b1);
            #1;
            checkOutput($sformatf("out[%0d]", i), out, vecs[i].exp_out);
            @(posedge clk);
            #1;
            checkRegs($sformatf("vec%0d", i), vecs[i].exp_out,
                      vecs[i].exp_onehot, vecs[i].exp_zero, vecs[i].exp_multi);
        end

        // Unknown select: only meaningful on a four-state simulator.
        xprobe     = 1'bx;
        four_state = $isunknown(xprobe);
        if (four_state) begin
            applyStimulus(8'bxxxxxxx1, 1'b1);
            #1;
            checkOutput("x out", out, 3'bxxx);
            @(posedge clk);
            #1;
            checkOutput("x out_q", out_q, 3'bxxx);
            checkOutput("x onehot_q", {2'b00, onehot_q}, {2'b00, 1'bx});
        end else begin
            $display("[TB] two-state simulator, unknown-select checks skipped");
        end

        // Hold: load 0x40, drop en, change select; registers keep 110.
        applyStimulus(8'h40, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("hold load out_q", out_q, 3'd6);
        applyStimulus(8'h02, 1'b0);
        @(posedge clk);
        #1;
        checkRegs("hold", 3'd6, 1'b1, 1'b0, 1'b0);
        checkOutput("hold comb out", out, 3'd1);

        // Asynchronous reset pulse between edges with en=1.
        @(negedge clk);
        en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkRegs("async_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;

        // First capture after reset release.
        @(posedge clk);
        #1;
        checkRegs("after_reset", 3'd1, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
